// File: rtl/alu_pkg.sv
// Shared ALUControl encoding and execution-unit state type.
// The ALU decoder imports the same constants, so the encoding is defined in one place.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input logic [2:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor shared by add, sub and slt.
// Subtraction is a + ~b + 1; carry is bit XLEN of the widened sum.
module alu_addsub #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sub,
    output logic [XLEN-1:0] sum,
    output logic            carry,
    output logic            ovf
);

    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum_wide;

    always_comb begin
        b_eff    = sub ? ~b : b;
        sum_wide = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
        sum      = sum_wide[XLEN-1:0];
        carry    = sum_wide[XLEN];
        ovf      = (a[XLEN-1] == b_eff[XLEN-1]) && (sum_wide[XLEN-1] != a[XLEN-1]);
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit: single-cycle logic/arith/slt, one-bit-per-cycle shifts,
// valid/ready handshake on both sides.
//
//   state    | meaning
//   ST_IDLE  | in_ready=1, waiting for an operation
//   ST_SHIFT | iterative shift in progress, counter holds remaining positions
//   ST_DONE  | out_valid=1, result/flags held until out_ready
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            neg,
    output logic            carry,
    output logic            ovf
);

    localparam int SHW = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;

    logic [XLEN-1:0] as_sum;
    logic            as_carry, as_ovf, as_sub;
    logic [SHW-1:0]  shamt;

    // slt reuses the subtract path
    assign as_sub = (alu_ctrl == ALU_SUB) || (alu_ctrl == ALU_SLT);
    assign shamt  = src_b[SHW-1:0];

    alu_addsub #(.XLEN(XLEN)) u_addsub (
        .a     (src_a),
        .b     (src_b),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry),
        .ovf   (as_ovf)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = alu_ctrl;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_DONE;
                    unique case (alu_ctrl)
                        ALU_ADD, ALU_SUB: begin
                            result_d = as_sum;
                            carry_d  = as_carry;
                            ovf_d    = as_ovf;
                        end
                        ALU_AND: result_d = src_a & src_b;
                        ALU_OR:  result_d = src_a | src_b;
                        ALU_XOR: result_d = src_a ^ src_b;
                        ALU_SLT: result_d = {{(XLEN-1){1'b0}}, as_sum[XLEN-1] ^ as_ovf};
                        default: begin
                            if (shamt == '0) begin
                                result_d = src_a;
                            end else begin
                                work_d  = src_a;
                                cnt_d   = shamt;
                                state_d = ST_SHIFT;
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                work_d = (op_q == ALU_SLL) ? (work_q << 1) : (work_q >> 1);
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    result_d = work_d;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= ALU_ADD;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign neg       = result_q[XLEN-1];
    assign carry     = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors for arithmetic flags, slt,
// shift latency, zero shift amount, backpressure and reset abort.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid === 1'b1) begin
            assert (!$isunknown(alu_ctrl)) else begin
                n_err++;
                $error("FAIL alu_ctrl_x: observed=%b required=known", alu_ctrl);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h required=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one operation for a single cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_ctrl = op;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = ALU_ADD;
        src_a     = '0;
        src_b     = '0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // add with signed overflow
        issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", result, 32'h8000_0000);
        chk("add_neg", 32'(neg), 32'd1);
        chk("add_ovf", 32'(ovf), 32'd1);
        chk("add_carry", 32'(carry), 32'd0);
        chk("add_zero", 32'(zero), 32'd0);
        chk("add_in_ready", 32'(in_ready), 32'd0);
        drain();
        chk("add_drain_in_ready", 32'(in_ready), 32'd1);
        chk("add_drain_valid", 32'(out_valid), 32'd0);

        issue(ALU_SUB, 32'd5, 32'd5);
        chk("sub_result", result, 32'h0);
        chk("sub_zero", 32'(zero), 32'd1);
        chk("sub_carry", 32'(carry), 32'd1);
        chk("sub_ovf", 32'(ovf), 32'd0);
        drain();

        // borrow case: 3 - 5
        issue(ALU_SUB, 32'd3, 32'd5);
        chk("subb_result", result, 32'hFFFF_FFFE);
        chk("subb_carry", 32'(carry), 32'd0);
        chk("subb_neg", 32'(neg), 32'd1);
        drain();

        issue(ALU_SLT, 32'hFFFF_FFFF, 32'h1);
        chk("slt_neg1_result", result, 32'h1);
        chk("slt_carry", 32'(carry), 32'd0);
        drain();

        // overflowing compare: 0x7FFFFFFF < 0x80000000 is false when signed
        issue(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
        chk("slt_ovf_result", result, 32'h0);
        chk("slt_ovf_flag", 32'(ovf), 32'd0);
        drain();

        issue(ALU_OR, 32'h0000_F0F0, 32'h0F00_000F);
        chk("or_result", result, 32'h0F00_F0FF);
        drain();
        issue(ALU_XOR, 32'hFFFF_0000, 32'hFF00_FF00);
        chk("xor_result", result, 32'h00FF_FF00);
        drain();

        // sll by 31: out_valid rises exactly 31 cycles after the accepting edge
        issue(ALU_SLL, 32'h1, 32'h1F);
        chk("sll_in_ready_busy", 32'(in_ready), 32'd0);
        for (int i = 0; i < 30; i++) step();
        chk("sll_not_early", 32'(out_valid), 32'd0);
        step();
        chk("sll_valid", 32'(out_valid), 32'd1);
        chk("sll_result", result, 32'h8000_0000);
        chk("sll_neg", 32'(neg), 32'd1);
        drain();

        // srl, upper src_b bits ignored (0x24 -> shamt 4)
        issue(ALU_SRL, 32'h8000_0000, 32'h24);
        for (int i = 0; i < 3; i++) step();
        chk("srl_not_early", 32'(out_valid), 32'd0);
        step();
        chk("srl_valid", 32'(out_valid), 32'd1);
        chk("srl_result", result, 32'h0800_0000);
        chk("srl_neg", 32'(neg), 32'd0);
        drain();

        issue(ALU_SLL, 32'h1234, 32'h20);
        chk("sh0_valid", 32'(out_valid), 32'd1);
        chk("sh0_result", result, 32'h1234);
        drain();

        // backpressure with an ignored second request
        issue(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                alu_ctrl = ALU_ADD;
                src_a    = 32'h1;
                src_b    = 32'h1;
                in_valid = 1'b1;
            end
            chk("bp_result", result, 32'h0000_F000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            step();
            in_valid = 1'b0;
        end
        chk("bp_result_end", result, 32'h0000_F000);
        drain();
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        step();
        chk("bp_no_ghost_op", 32'(out_valid), 32'd0);

        // reset in the middle of a shift
        issue(ALU_SLL, 32'h1, 32'h1F);
        step();
        step();
        chk("mid_shift_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_result", result, 32'h0);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 35; i++) step();
        chk("rst2_no_partial", 32'(out_valid), 32'd0);

        // unit still works after the abort
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
        chk("post_rst_result", result, 32'h0);
        chk("post_rst_carry", 32'(carry), 32'd1);
        chk("post_rst_zero", 32'(zero), 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
